cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
Shares the single physical-memory line port between the I-cache (serves `i_mem_*` of the pipeline) and the D-cache (serves `d_mem_*`). It sits between the two caches and physical memory. A three-state FSM grants exactly one requester per transaction and holds the grant until physical memory responds. It then routes the response and read line back to the owner only.

Parameters:
- LINE_WIDTH, 128, cache line width in bits (8 words).
- ADDR_WIDTH, 16, byte address width (`lc3b_word`).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous active-high reset.
- i_pmem_read  input  1  I-cache line-fill request.
- i_pmem_address  input  ADDR_WIDTH  I-cache line address.
- i_pmem_rdata  output  LINE_WIDTH  line data to I-cache.
- i_pmem_resp  output  1  I-cache transaction complete.
- d_pmem_read  input  1  D-cache line-fill request.
- d_pmem_write  input  1  D-cache writeback request.
- d_pmem_address  input  ADDR_WIDTH  D-cache line address.
- d_pmem_wdata  input  LINE_WIDTH  writeback line.
- d_pmem_rdata  output  LINE_WIDTH  line data to D-cache.
- d_pmem_resp  output  1  D-cache transaction complete.
- pmem_read  output  1  read command to physical memory.
- pmem_write  output  1  write command to physical memory.
- pmem_address  output  ADDR_WIDTH  physical address.
- pmem_wdata  output  LINE_WIDTH  write line.
- pmem_rdata  input  LINE_WIDTH  read line from memory.
- pmem_resp  input  1  memory transaction complete.

Behaviour:
- Clock and reset: one clock `clk`; reset `reset` is synchronous, active-high.
- States: IDLE, I_ACC, D_ACC. Reset forces IDLE.
- Reset values: all outputs are 0 in reset and in IDLE.
- IDLE:
  - `d_req = d_pmem_read | d_pmem_write`.
  - `d_req` -> D_ACC; else `i_pmem_read` -> I_ACC; else stay in IDLE.
  - Fixed priority is D over I, because D-cache misses stall MEM with older instructions.
- I_ACC:
  - `pmem_read = 1`, `pmem_write = 0`.
  - `pmem_address = i_pmem_address`.
- D_ACC:
  - `pmem_read = d_pmem_read & ~d_pmem_write`.
  - `pmem_write = d_pmem_write`. If read and write are both asserted, write wins.
  - `pmem_address = d_pmem_address`, `pmem_wdata = d_pmem_wdata`.
- Command outputs are combinational from state plus the owner's live inputs. Requesters hold their inputs stable until they see resp.
- Latency: a request sampled in IDLE at edge N produces the memory command in cycle N+1. Arbitration overhead is one cycle.
- Completion:
  - While in X_ACC with `pmem_resp = 1`, `X_pmem_resp = 1` in that same cycle.
  - `X_pmem_rdata = pmem_rdata` (pass-through). The non-owner's resp stays 0.
  - Next state is IDLE, which gives a mandatory one-cycle bubble. Requesters drop or replace their request on the cycle after resp.
- rdata gating: `i_pmem_rdata` and `d_pmem_rdata` are driven to 0 when the port is not the owner.
- Owner drops request mid-transaction (illegal): the FSM stays in X_ACC until `pmem_resp`. Command outputs follow the owner's live inputs, so they go low.
- `pmem_resp` in IDLE: ignored, no resp forwarded.
- Reset mid-transaction: returns to IDLE next edge and all outputs go low. Physical memory must be reset in the same cycle.
- Simultaneous new requests while busy: not sampled until IDLE, then priority applies.

Optional Feature:
- Macro: `ARB_ROUND_ROBIN_EN`.
- Defined:
  - One `last_grant` flop, reset value I, updated on entry to I_ACC or D_ACC.
  - When both requests are pending in IDLE, the grant goes to the port not in `last_grant`.
  - A single request is granted immediately, as in the undefined case.
- Undefined: fixed D>I priority; no `last_grant` flop exists.

Decomposition:
- In the shared `lc3b_types` package:
  - `lc3b_pmem_line` (LINE_WIDTH logic vector).
  - `lc3b_arb_state` enum {IDLE, I_ACC, D_ACC}.
  - `lc3b_arb_owner` enum {OWN_I, OWN_D}.
- Sub-module: none. Next-state logic and the output mux are one always_comb each, plus one always_ff for state (and `last_grant`).

Test Plan:
- I-only read: `i_pmem_read = 1`, addr `16'h0120`, memory resp after 3 cycles with `128'hA5..` -> `pmem_read` rises cycle N+1 with addr `0x0120`; `i_pmem_resp = 1` for exactly one cycle with rdata `A5..`; `d_pmem_resp` stays 0.
- Simultaneous I read `0x0040` and D write `0x0200`, without the macro -> D serviced first (`pmem_write = 1`, addr `0x0200`, wdata matches), one IDLE bubble, then I read of `0x0040`.
- Same stimulus with `ARB_ROUND_ROBIN_EN` defined and `last_grant = D` -> I granted first, then D.
- D read and write both asserted, addr `0x0300` -> `pmem_write = 1`, `pmem_read = 0`.
- Reset asserted during D_ACC before resp -> next cycle state is IDLE, all outputs 0; a later `pmem_resp` pulse produces no resp.
- `pmem_resp` pulsed while IDLE with no requests -> both resp outputs remain 0; state stays IDLE.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the memory arbiter.
// Line width, arbiter FSM states and requester ownership.
package lc3b_types;

    localparam int LC3B_LINE_WIDTH = 128;
    localparam int LC3B_ADDR_WIDTH = 16;

    typedef logic [LC3B_LINE_WIDTH-1:0] lc3b_pmem_line;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2
    } lc3b_arb_state;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } lc3b_arb_owner;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Grants the physical-memory line port to the I-cache or D-cache, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention instead of fixed D-over-I priority.
module cache_mem_arbiter
    import lc3b_types::*;
#(
    parameter int LINE_WIDTH = 128,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    lc3b_arb_state state, next_state, both_grant, out_state;
    logic          d_req;

    assign d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
    lc3b_arb_owner last_grant;

    // On contention, hand the port to whoever was not served last.
    assign both_grant = (last_grant == OWN_D) ? I_ACC : D_ACC;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= OWN_I;
        end else if (state == IDLE && next_state == I_ACC) begin
            last_grant <= OWN_I;
        end else if (state == IDLE && next_state == D_ACC) begin
            last_grant <= OWN_D;
        end
    end
`else
    // D-cache misses stall older instructions in MEM, so D wins ties.
    assign both_grant = D_ACC;
`endif

    // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (d_req && i_pmem_read) next_state = both_grant;
                else if (d_req)           next_state = D_ACC;
                else if (i_pmem_read)     next_state = I_ACC;
            end
            I_ACC, D_ACC: begin
                if (pmem_resp) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Outputs are held low for the whole reset cycle, even before the state flop clears.
    assign out_state = reset ? IDLE : state;

    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_rdata = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_rdata = '0;
        d_pmem_resp  = 1'b0;
        case (out_state)
            I_ACC: begin
                pmem_read    = 1'b1;
                pmem_address = i_pmem_address;
                i_pmem_rdata = pmem_rdata;
                i_pmem_resp  = pmem_resp;
            end
            D_ACC: begin
                // Write takes precedence if a misbehaving D-cache asserts both.
                pmem_read    = d_pmem_read & ~d_pmem_write;
                pmem_write   = d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_rdata = pmem_rdata;
                d_pmem_resp  = pmem_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: transaction-level ownership model plus directed checks.
// Honours ARB_ROUND_ROBIN_EN in the same way the design does.
module tb_cache_mem_arbiter;

    localparam int LW = 128;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    int total = 0;
    int bad   = 0;

    cache_mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ownership model: 0 = nobody, 1 = I-cache, 2 = D-cache.
    int m_owner  = 0;
    bit m_last_d = 1'b0;
    logic m_dreq;
    assign m_dreq = d_pmem_read | d_pmem_write;

    always @(posedge clk) begin
        if (reset) begin
            m_owner  <= 0;
            m_last_d <= 1'b0;
        end else if (m_owner == 0) begin
            if (m_dreq && i_pmem_read) begin
`ifdef ARB_ROUND_ROBIN_EN
                m_owner  <= m_last_d ? 1 : 2;
                m_last_d <= !m_last_d;
`else
                m_owner  <= 2;
                m_last_d <= 1'b1;
`endif
            end else if (m_dreq) begin
                m_owner  <= 2;
                m_last_d <= 1'b1;
            end else if (i_pmem_read) begin
                m_owner  <= 1;
                m_last_d <= 1'b0;
            end
        end else if (pmem_resp) begin
            m_owner <= 0;
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        logic          e_read, e_write, e_iresp, e_dresp;
        logic [AW-1:0] e_addr;
        logic [LW-1:0] e_wdata, e_irdata, e_drdata;
        e_read = 1'b0; e_write = 1'b0; e_iresp = 1'b0; e_dresp = 1'b0;
        e_addr = '0; e_wdata = '0; e_irdata = '0; e_drdata = '0;
        if (!reset && m_owner == 1) begin
            e_read   = 1'b1;
            e_addr   = i_pmem_address;
            e_iresp  = pmem_resp;
            e_irdata = pmem_rdata;
        end else if (!reset && m_owner == 2) begin
            e_write  = d_pmem_write;
            e_read   = d_pmem_read && !d_pmem_write;
            e_addr   = d_pmem_address;
            e_wdata  = d_pmem_wdata;
            e_dresp  = pmem_resp;
            e_drdata = pmem_rdata;
        end
        check("cyc_pmem_read",    LW'(pmem_read),    LW'(e_read));
        check("cyc_pmem_write",   LW'(pmem_write),   LW'(e_write));
        check("cyc_pmem_address", LW'(pmem_address), LW'(e_addr));
        check("cyc_pmem_wdata",   pmem_wdata,        e_wdata);
        check("cyc_i_resp",       LW'(i_pmem_resp),  LW'(e_iresp));
        check("cyc_d_resp",       LW'(d_pmem_resp),  LW'(e_dresp));
        check("cyc_i_rdata",      i_pmem_rdata,      e_irdata);
        check("cyc_d_rdata",      d_pmem_rdata,      e_drdata);
    end

    initial begin
        logic [LW-1:0] line_a5, line_3c, line_w1, line_w2, line_5a;
        line_a5 = {16{8'hA5}};
        line_3c = {16{8'h3C}};
        line_w1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        line_w2 = 128'hDEAD_BEEF_CAFE_F00D_1111_2222_3333_4444;
        line_5a = {16{8'h5A}};

        reset = 1'b1;
        i_pmem_read = 1'b0; i_pmem_address = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        tick(); tick();
        check("rst_pmem_read",  LW'(pmem_read),   '0);
        check("rst_pmem_write", LW'(pmem_write),  '0);
        check("rst_i_resp",     LW'(i_pmem_resp), '0);
        reset = 1'b0;
        tick();

        // I-only read, memory answers three cycles after the command.
        i_pmem_read = 1'b1; i_pmem_address = 16'h0120; #1;
        check("i_rd_idle_cycle", LW'(pmem_read), '0);
        tick();
        check("i_rd_cmd",  LW'(pmem_read),    LW'(1));
        check("i_rd_addr", LW'(pmem_address), LW'(16'h0120));
        tick(); tick();
        pmem_rdata = line_a5; pmem_resp = 1'b1; #1;
        check("i_rd_resp",   LW'(i_pmem_resp), LW'(1));
        check("i_rd_rdata",  i_pmem_rdata,     line_a5);
        check("i_rd_d_resp", LW'(d_pmem_resp), '0);
        tick();
        pmem_resp = 1'b0; i_pmem_read = 1'b0; #1;
        check("i_rd_resp_one_cycle", LW'(i_pmem_resp), '0);
        tick();

        // D read and write together: write wins.
        d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 16'h0300; d_pmem_wdata = line_w1;
        tick();
        check("drw_write", LW'(pmem_write),   LW'(1));
        check("drw_read",  LW'(pmem_read),    '0);
        check("drw_addr",  LW'(pmem_address), LW'(16'h0300));
        pmem_rdata = line_3c; pmem_resp = 1'b1; #1;
        check("drw_resp",    LW'(d_pmem_resp), LW'(1));
        check("drw_i_rdata", i_pmem_rdata,     '0);
        tick();
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; pmem_resp = 1'b0;
        tick();

        // Contention: I read 0x0040 against D write 0x0200 (previous grant was D).
        i_pmem_read = 1'b1; i_pmem_address = 16'h0040;
        d_pmem_write = 1'b1; d_pmem_address = 16'h0200; d_pmem_wdata = line_w2;
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        check("rr_first_i_read", LW'(pmem_read),    LW'(1));
        check("rr_first_i_addr", LW'(pmem_address), LW'(16'h0040));
        pmem_rdata = line_5a; pmem_resp = 1'b1; #1;
        check("rr_first_i_resp", LW'(i_pmem_resp), LW'(1));
        tick();
        i_pmem_read = 1'b0; pmem_resp = 1'b0; #1;
        check("rr_bubble_read",  LW'(pmem_read),  '0);
        check("rr_bubble_write", LW'(pmem_write), '0);
        tick();
        check("rr_second_d_write", LW'(pmem_write),   LW'(1));
        check("rr_second_d_addr",  LW'(pmem_address), LW'(16'h0200));
        check("rr_second_d_wdata", pmem_wdata,        line_w2);
        pmem_resp = 1'b1;
        tick();
        d_pmem_write = 1'b0; pmem_resp = 1'b0;
`else
        check("pri_first_d_write", LW'(pmem_write),   LW'(1));
        check("pri_first_d_addr",  LW'(pmem_address), LW'(16'h0200));
        check("pri_first_d_wdata", pmem_wdata,        line_w2);
        pmem_resp = 1'b1; #1;
        check("pri_first_d_resp", LW'(d_pmem_resp), LW'(1));
        tick();
        d_pmem_write = 1'b0; pmem_resp = 1'b0; #1;
        check("pri_bubble_read",  LW'(pmem_read),  '0);
        check("pri_bubble_write", LW'(pmem_write), '0);
        tick();
        check("pri_second_i_read", LW'(pmem_read),    LW'(1));
        check("pri_second_i_addr", LW'(pmem_address), LW'(16'h0040));
        pmem_rdata = line_5a; pmem_resp = 1'b1;
        tick();
        i_pmem_read = 1'b0; pmem_resp = 1'b0;
`endif
        tick();

        // Owner drops its request mid-transaction; a new I request waits for IDLE.
        d_pmem_read = 1'b1; d_pmem_address = 16'h0500;
        tick();
        check("drop_cmd", LW'(pmem_read), LW'(1));
        d_pmem_read = 1'b0; #1;
        check("drop_cmd_low", LW'(pmem_read), '0);
        tick();
        i_pmem_read = 1'b1; i_pmem_address = 16'h0600;
        tick();
        check("busy_no_i_grant", LW'(pmem_read), '0);
        pmem_rdata = line_a5; pmem_resp = 1'b1; #1;
        check("drop_d_resp", LW'(d_pmem_resp), LW'(1));
        check("drop_i_resp", LW'(i_pmem_resp), '0);
        tick();
        pmem_resp = 1'b0;
        tick();
        check("late_i_addr", LW'(pmem_address), LW'(16'h0600));
        pmem_resp = 1'b1;
        tick();
        i_pmem_read = 1'b0; pmem_resp = 1'b0;
        tick();

        // Reset during D_ACC before the response.
        d_pmem_read = 1'b1; d_pmem_address = 16'h0400;
        tick();
        check("rstmid_cmd", LW'(pmem_read), LW'(1));
        reset = 1'b1; #1;
        check("rstmid_gated", LW'(pmem_read), '0);
        tick();
        reset = 1'b0; d_pmem_read = 1'b0; #1;
        check("rstmid_idle_read", LW'(pmem_read),    '0);
        check("rstmid_idle_addr", LW'(pmem_address), '0);
        pmem_resp = 1'b1; #1;
        check("rstmid_no_d_resp", LW'(d_pmem_resp), '0);
        check("rstmid_no_i_resp", LW'(i_pmem_resp), '0);
        tick();
        pmem_resp = 1'b0;
        tick();

        // Stray pmem_resp while idle.
        pmem_resp = 1'b1; #1;
        check("idle_resp_i", LW'(i_pmem_resp), '0);
        check("idle_resp_d", LW'(d_pmem_resp), '0);
        tick();
        pmem_resp = 1'b0; #1;
        check("idle_stays_idle", LW'(pmem_read), '0);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
